alu_word_sequencer: RTL and testbench

- Multi-precision sequencer for the N-bit arithmetic unit (add / negate-add / increment / decrement datapath with carry in/out).
- Performs ADD, SUB, INC and DEC on W-word operands (W*N bits) by feeding the unit one word per cycle, LSW first, chaining the carry through a register.
- Sits between the top-level control/register file and the arithmetic unit; the unit itself is instantiated outside this block.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_word_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_word_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the multi-precision ALU word sequencer.
// Op codes, FSM states and the arithmetic unit select value.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] ALU_SEL_ADD = 2'b00;

  function automatic logic carry_seed(
    input logic [1:0] op,
    input logic       cin
  );
    logic s;
    s = 1'b0;
    unique case (op)
      OP_ADD: s = cin;
      OP_SUB: s = 1'b1;
      OP_INC: s = 1'b1;
      OP_DEC: s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_word_sequencer.sv
// W-word ADD/SUB/INC/DEC sequencer over an external N-bit adder, LSW first.
// Optional ALU_WORD_SEQ_OVF_EN enables the signed overflow flag.
module alu_word_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic           cin,
  input  logic [W*N-1:0] opa,
  input  logic [W*N-1:0] opb,
  output logic           busy,
  output logic           done,
  output logic [W*N-1:0] result,
  output logic           carry_out,
  output logic           zero,
  output logic           ovf,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic           alu_cin,
  output logic [1:0]     alu_sel,
  input  logic [N-1:0]   alu_res,
  input  logic           alu_cout
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  logic [1:0]            state;
  logic [1:0]            op_q;
  logic [IW-1:0]         idx;
  logic                  carry_q;
  logic                  carry_out_q;
  logic                  zero_q;
  logic [W-1:0][N-1:0]   a_q;
  logic [W-1:0][N-1:0]   b_q;
  logic [W-1:0][N-1:0]   result_q;
  logic [W-1:0][N-1:0]   res_next;
  logic [N-1:0]          a_word;
  logic [N-1:0]          b_cond;
  logic                  in_exec;
  logic                  last;

  assign in_exec = (state == S_EXEC);
  assign last    = (idx == IW'(W - 1));

  always_comb begin
    a_word = a_q[idx];
    b_cond = b_q[idx];
    unique case (op_q)
      OP_ADD: b_cond = b_q[idx];
      OP_SUB: b_cond = ~b_q[idx];
      OP_INC: b_cond = '0;
      OP_DEC: b_cond = '1;
    endcase
  end

  always_comb begin
    res_next      = result_q;
    res_next[idx] = alu_res;
  end

  assign alu_a   = in_exec ? a_word : '0;
  assign alu_b   = in_exec ? b_cond : '0;
  assign alu_cin = in_exec & carry_q;
  assign alu_sel = ALU_SEL_ADD;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;

`ifdef ALU_WORD_SEQ_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      ovf_q <= 1'b0;
    end else if (in_exec && last) begin
      ovf_q <= (a_word[N-1] == b_cond[N-1]) &&
               (alu_res[N-1] != a_word[N-1]);
    end
  end
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= OP_ADD;
      idx         <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_q         <= opa;
            b_q         <= opb;
            op_q        <= op;
            idx         <= '0;
            carry_q     <= carry_seed(op, cin);
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q <= res_next;
          carry_q  <= alu_cout;
          if (last) begin
            carry_out_q <= alu_cout;
            zero_q      <= (res_next == '0);
            state       <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer with a behavioural N-bit adder.
// Define ALU_WORD_SEQ_OVF_EN for both RTL and bench to check the ovf flag.
module tb_alu_word_sequencer;

  localparam int N = 4;
  localparam int W = 4;

`ifdef ALU_WORD_SEQ_OVF_EN
  localparam logic OVF_7FFF = 1'b1;
`else
  localparam logic OVF_7FFF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic         cin;
  logic [15:0]  opa;
  logic [15:0]  opb;
  logic         busy;
  logic         done;
  logic [15:0]  result;
  logic         carry_out;
  logic         zero;
  logic         ovf;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         alu_cin;
  logic [1:0]   alu_sel;
  logic [N-1:0] alu_res;
  logic         alu_cout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};

  alu_word_sequencer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .cin       (cin),
    .opa       (opa),
    .opb       (opb),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .ovf       (ovf),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_sel   (alu_sel),
    .alu_res   (alu_res),
    .alu_cout  (alu_cout)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [15:0] er,
                       input logic ec, input logic ez, input logic eo);
    int lat;
    lat = 0;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; cin = c;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy1"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check({tag, " lat"}, 32'(lat), 32'd5);
    check({tag, " res"}, 32'(result), 32'(er));
    check({tag, " cout"}, 32'(carry_out), 32'(ec));
    check({tag, " zero"}, 32'(zero), 32'(ez));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
    check({tag, " idle"}, {30'b0, busy, done}, 32'd0);
    check({tag, " hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    logic [11:0] busy_v;
    logic [11:0] done_v;
    int          n_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; cin = 1'b0;
    opa = '0; opb = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst res", 32'(result), 32'd0);
    check("rst flags", {29'b0, carry_out, zero, ovf}, 32'd0);
    check("rst alu", {24'b0, alu_a, alu_b}, 32'd0);
    check("sel", 32'(alu_sel), 32'd0);
    rst = 1'b0;

    do_op("add", 2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    do_op("addc", 2'b00, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    do_op("sub1", 2'b01, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    do_op("sub2", 2'b01, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    do_op("inc", 2'b10, 16'hFFFF, 16'h5555, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    do_op("dec", 2'b11, 16'h0000, 16'h5555, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    do_op("ovf", 2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, OVF_7FFF);

    // second start during EXEC must be dropped
    busy_v = '0; done_v = '0; n_done = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; opa = 16'h0001; opb = 16'h0001; cin = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      busy_v[c-1] = busy;
      done_v[c-1] = done;
      if (done) begin
        n_done++;
        check("busy-start res", 32'(result), 32'h0002);
      end
      start = (c == 2);
    end
    check("busy-start busy", 32'(busy_v), 32'h01F);
    check("busy-start done", 32'(done_v), 32'h010);
    check("busy-start n", 32'(n_done), 32'd1);

    // reset in the middle of an operation
    n_done = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; opa = 16'h1111; opb = 16'h2222;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid-rst busy", 32'(busy), 32'd0);
    check("mid-rst res", 32'(result), 32'd0);
    check("mid-rst done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mid-rst nodone", 32'(n_done), 32'd0);
    do_op("post-rst", 2'b00, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
